// File: rtl/dds4ch_sample_source.sv
// Four-channel DDS sine source: one shared quarter-wave LUT and one multiplier,
// time-multiplexed; all four samples commit together under a single o_ce strobe.
module dds4ch_sample_source #(
   parameter int CLK_DIV = 1000
) (
   input  logic        clk100mhz,
   input  logic        rstn,
   input  logic        i_enable,
   input  logic        i_sync,
   input  logic        i_cfg_we,
   input  logic [1:0]  i2_cfg_ch,
   input  logic [31:0] i32_cfg_ftw,
   input  logic [15:0] i16_cfg_amp,
   output logic [15:0] os16_data_ch0,
   output logic [15:0] os16_data_ch1,
   output logic [15:0] os16_data_ch2,
   output logic [15:0] os16_data_ch3,
   output logic        o_ce,
   output logic        o_busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ADDR   = 3'd1;
   localparam logic [2:0] S_LUT    = 3'd2;
   localparam logic [2:0] S_MUL    = 3'd3;
   localparam logic [2:0] S_STORE  = 3'd4;
   localparam logic [2:0] S_COMMIT = 3'd5;

   logic [15:0] div_cnt;
   logic        tick;
   logic [2:0]  state;
   logic [1:0]  ch;
   logic        start;

   logic [31:0] ftw_pend [4];
   logic [15:0] amp_pend [4];
   logic [31:0] ftw_act  [4];
   logic [15:0] amp_act  [4];
   logic [31:0] acc      [4];

   logic [9:0]  phase_top;
   logic [7:0]  lut_addr;
   logic        neg;
   logic [14:0] mag;
   logic [14:0] prod;
   logic [15:0] store_val;
   logic [15:0] sh0;
   logic [15:0] sh1;
   logic [15:0] sh2;
   logic [14:0] sine_rom [256];

   function automatic logic [14:0] sine_entry(input int k);
      real v;
      v = 32767.0 * $sin(3.14159265358979323846 * real'(k) / 512.0);
      return 15'($rtoi(v + 0.5));
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 256; gi++) begin : g_rom
         assign sine_rom[gi] = sine_entry(gi);
      end
   endgenerate

   // Tick is registered, so a sequence starts the cycle after the tick is seen.
   always_ff @(posedge clk100mhz or negedge rstn) begin
      if (!rstn) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (!i_enable) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == 16'(CLK_DIV - 1)) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 16'd1;
         tick    <= 1'b0;
      end
   end

   assign start = tick && (state == S_IDLE);

   always_ff @(posedge clk100mhz or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 4; i++) begin
            ftw_pend[i] <= '0;
            amp_pend[i] <= '0;
            ftw_act[i]  <= '0;
            amp_act[i]  <= '0;
            acc[i]      <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (i_cfg_we && (i2_cfg_ch == 2'(i))) begin
               ftw_pend[i] <= i32_cfg_ftw;
               amp_pend[i] <= i16_cfg_amp;
            end
            // A write landing in the tick cycle is forwarded into the active copy.
            if (start) begin
               if (i_cfg_we && (i2_cfg_ch == 2'(i))) begin
                  ftw_act[i] <= i32_cfg_ftw;
                  amp_act[i] <= i16_cfg_amp;
               end else begin
                  ftw_act[i] <= ftw_pend[i];
                  amp_act[i] <= amp_pend[i];
               end
            end
            if (i_sync) begin
               acc[i] <= '0;
            end else if (state == S_COMMIT) begin
               acc[i] <= acc[i] + ftw_act[i];
            end
         end
      end
   end

   always_ff @(posedge clk100mhz or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         ch    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_ADDR;
                  ch    <= '0;
               end
            end
            S_ADDR:  state <= S_LUT;
            S_LUT:   state <= S_MUL;
            S_MUL:   state <= S_STORE;
            S_STORE: begin
               if (ch != 2'd3) begin
                  ch    <= ch + 2'd1;
                  state <= S_ADDR;
               end else begin
                  state <= S_COMMIT;
               end
            end
            S_COMMIT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   assign phase_top = acc[ch][31:22];
   assign store_val = neg ? (16'd0 - {1'b0, prod}) : {1'b0, prod};

   always_ff @(posedge clk100mhz) begin
      if (state == S_LUT) begin
         mag <= sine_rom[lut_addr];
      end
   end

   // Outputs load on the last STORE edge so they are already valid while o_ce is high.
   always_ff @(posedge clk100mhz or negedge rstn) begin
      if (!rstn) begin
         lut_addr      <= '0;
         neg           <= 1'b0;
         prod          <= '0;
         sh0           <= '0;
         sh1           <= '0;
         sh2           <= '0;
         os16_data_ch0 <= '0;
         os16_data_ch1 <= '0;
         os16_data_ch2 <= '0;
         os16_data_ch3 <= '0;
      end else begin
         if (state == S_ADDR) begin
            lut_addr <= phase_top[8] ? ~phase_top[7:0] : phase_top[7:0];
            neg      <= phase_top[9];
         end
         if (state == S_MUL) begin
            prod <= 15'((31'(mag) * 31'(amp_act[ch])) >> 16);
         end
         if (state == S_STORE) begin
            case (ch)
               2'd0: sh0 <= store_val;
               2'd1: sh1 <= store_val;
               2'd2: sh2 <= store_val;
               default: begin
                  os16_data_ch0 <= sh0;
                  os16_data_ch1 <= sh1;
                  os16_data_ch2 <= sh2;
                  os16_data_ch3 <= store_val;
               end
            endcase
         end
      end
   end

   assign o_ce   = (state == S_COMMIT);
   assign o_busy = (state != S_IDLE);

endmodule
